// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read ports, write ports and the reserve request.
// Parameters must match the regfile_mp instance the bundle connects to.
interface regfile_mp_if #(
  parameter int RAWIDTH = 5,
  parameter int DWIDTH  = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2
);
  logic [NRD*RAWIDTH-1:0] RdAddr;
  logic [NRD*DWIDTH-1:0]  RdData;
  logic [NRD-1:0]         RdBusy;
  logic [NWR-1:0]         WrEn;
  logic [NWR*RAWIDTH-1:0] WrAddr;
  logic [NWR*DWIDTH-1:0]  WrData;
  logic                   ResEn;
  logic [RAWIDTH-1:0]     ResAddr;

  modport master (
    output RdAddr, WrEn, WrAddr, WrData, ResEn, ResAddr,
    input  RdData, RdBusy
  );

  modport slave (
    input  RdAddr, WrEn, WrAddr, WrData, ResEn, ResAddr,
    output RdData, RdBusy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending scoreboard.
// x0 is hardwired to zero; reads are combinational with optional write bypass.
module regfile_mp #(
  parameter int RAWIDTH = 5,
  parameter int DWIDTH  = 32,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter bit BYPASS  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  regfile_mp_if.slave   bus
);
  localparam int DEPTH = 2**RAWIDTH;

  logic [DWIDTH-1:0] memArr [1:DEPTH-1];
  logic [DEPTH-1:1]  pendVec;

  genvar gi;

  // One storage word and pending bit per architectural register except x0.
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : gReg
      logic [DWIDTH-1:0] dataReg;
      logic [DWIDTH-1:0] dataNext;
      logic              wrHit;
      logic              pendReg;
      logic              pendNext;

      always_comb begin
        wrHit    = 1'b0;
        dataNext = dataReg;
        // Ascending scan so the highest-index port wins a collision.
        for (int p = 0; p < NWR; p++) begin
          if (bus.WrEn[p] && (bus.WrAddr[p*RAWIDTH +: RAWIDTH] == RAWIDTH'(gi))) begin
            wrHit    = 1'b1;
            dataNext = bus.WrData[p*DWIDTH +: DWIDTH];
          end
        end
        pendNext = pendReg;
        if (wrHit) pendNext = 1'b0;
        // A reservation overrides a same-cycle write-clear.
        if (bus.ResEn && (bus.ResAddr == RAWIDTH'(gi))) pendNext = 1'b1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dataReg <= '0;
          pendReg <= 1'b0;
        end else begin
          dataReg <= dataNext;
          pendReg <= pendNext;
        end
      end

      assign memArr[gi]  = dataReg;
      assign pendVec[gi] = pendReg;
    end
  endgenerate

  generate
    for (gi = 0; gi < NRD; gi++) begin : gRd
      logic [RAWIDTH-1:0] rdAddr;
      logic [DWIDTH-1:0]  rdVal;
      logic               rdBusy;

      assign rdAddr = bus.RdAddr[gi*RAWIDTH +: RAWIDTH];

      // Gating with rst_n keeps bypassed write data off the outputs during reset.
      always_comb begin
        rdVal  = '0;
        rdBusy = 1'b0;
        if (rst_n && (rdAddr != '0)) begin
          rdVal  = memArr[rdAddr];
          rdBusy = pendVec[rdAddr];
          if (BYPASS) begin
            for (int p = 0; p < NWR; p++) begin
              if (bus.WrEn[p] && (bus.WrAddr[p*RAWIDTH +: RAWIDTH] == rdAddr)) begin
                rdVal  = bus.WrData[p*DWIDTH +: DWIDTH];
                rdBusy = 1'b0;
              end
            end
          end
        end
      end

      assign bus.RdData[gi*DWIDTH +: DWIDTH] = rdVal;
      assign bus.RdBusy[gi]                  = rdBusy;
    end
  endgenerate
endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: one BYPASS=1 and one BYPASS=0 instance share stimulus and
// are compared every cycle against a behavioural register-file model.
module tb_regfile_mp;
  localparam int RA  = 5;
  localparam int DW  = 32;
  localparam int NRD = 3;
  localparam int NWR = 2;
  localparam int NRAND = 10000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*RA-1:0] rdA = '0;
  logic [NWR-1:0]    we  = '0;
  logic [NWR*RA-1:0] wa  = '0;
  logic [NWR*DW-1:0] wd  = '0;
  logic              re  = 1'b0;
  logic [RA-1:0]     ra  = '0;

  regfile_mp_if #(.RAWIDTH(RA), .DWIDTH(DW), .NRD(NRD), .NWR(NWR)) ifB ();
  regfile_mp_if #(.RAWIDTH(RA), .DWIDTH(DW), .NRD(NRD), .NWR(NWR)) ifN ();

  assign ifB.RdAddr = rdA; assign ifN.RdAddr = rdA;
  assign ifB.WrEn   = we;  assign ifN.WrEn   = we;
  assign ifB.WrAddr = wa;  assign ifN.WrAddr = wa;
  assign ifB.WrData = wd;  assign ifN.WrData = wd;
  assign ifB.ResEn  = re;  assign ifN.ResEn  = re;
  assign ifB.ResAddr = ra; assign ifN.ResAddr = ra;

  regfile_mp #(.RAWIDTH(RA), .DWIDTH(DW), .NRD(NRD), .NWR(NWR), .BYPASS(1'b1)) uByp (
    .clk(clk), .rst_n(rst_n), .bus(ifB));
  regfile_mp #(.RAWIDTH(RA), .DWIDTH(DW), .NRD(NRD), .NWR(NWR), .BYPASS(1'b0)) uNoByp (
    .clk(clk), .rst_n(rst_n), .bus(ifN));

  typedef struct {
    int                id;
    logic [NRD*RA-1:0] addr;
    logic [NRD*DW-1:0] dB;
    logic [NRD*DW-1:0] dN;
    logic [NRD-1:0]    bB;
    logic [NRD-1:0]    bN;
  } exp_t;

  exp_t expQ[$];
  int checkCnt = 0;
  int passCnt  = 0;
  int txnId    = 0;

  // Reference model: architectural state as plain arrays.
  logic [DW-1:0] modMem  [32];
  bit            modPend [32];

  function automatic void modelRead(input bit byp, input logic [RA-1:0] a,
                                    output logic [DW-1:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (rst_n && a != 0) begin
      d = modMem[a];
      b = modPend[a];
      if (byp) begin
        for (int p = 0; p < NWR; p++)
          if (we[p] && wa[p*RA +: RA] == a) begin
            d = wd[p*DW +: DW];
            b = 1'b0;
          end
      end
    end
  endfunction

  task automatic modelEdge();
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) begin
        modMem[r]  = '0;
        modPend[r] = 1'b0;
      end
    end else begin
      for (int p = 0; p < NWR; p++)
        if (we[p] && wa[p*RA +: RA] != 0) begin
          modMem[wa[p*RA +: RA]]  = wd[p*DW +: DW];
          modPend[wa[p*RA +: RA]] = 1'b0;
        end
      if (re && ra != 0) modPend[ra] = 1'b1;
    end
  endtask

  // Drive one cycle of stimulus (at posedge+1), queue the expectation, advance.
  task automatic step(input logic [NRD*RA-1:0] r, input logic [NWR-1:0] e,
                      input logic [NWR*RA-1:0] a, input logic [NWR*DW-1:0] d,
                      input logic rs, input logic [RA-1:0] rsa);
    exp_t x;
    logic [DW-1:0] v;
    logic bz;
    rdA = r; we = e; wa = a; wd = d; re = rs; ra = rsa;
    x.id = txnId;
    x.addr = r;
    x.dB = '0; x.dN = '0; x.bB = '0; x.bN = '0;
    for (int i = 0; i < NRD; i++) begin
      modelRead(1'b1, r[i*RA +: RA], v, bz);
      x.dB[i*DW +: DW] = v; x.bB[i] = bz;
      modelRead(1'b0, r[i*RA +: RA], v, bz);
      x.dN[i*DW +: DW] = v; x.bN[i] = bz;
    end
    expQ.push_back(x);
    txnId++;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  function automatic logic [NRD*RA-1:0] rd3(input int a0, input int a1, input int a2);
    return {RA'(a2), RA'(a1), RA'(a0)};
  endfunction

  function automatic logic [NWR*RA-1:0] wa2(input int a0, input int a1);
    return {RA'(a1), RA'(a0)};
  endfunction

  task automatic chk(input string name, input int id, input int port,
                     input logic [DW-1:0] got, input logic [DW-1:0] want);
    checkCnt++;
    if (got === want) passCnt++;
    else $display("FAIL %s txn=%0d port=%0d got=%h want=%h", name, id, port, got, want);
  endtask

  // Monitor: outputs are combinational, so compare once per cycle mid-period.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        x = expQ.pop_front();
        for (int i = 0; i < NRD; i++) begin
          chk("rdData_byp",   x.id, i, ifB.RdData[i*DW +: DW], x.dB[i*DW +: DW]);
          chk("rdBusy_byp",   x.id, i, DW'(ifB.RdBusy[i]),     DW'(x.bB[i]));
          chk("rdData_nobyp", x.id, i, ifN.RdData[i*DW +: DW], x.dN[i*DW +: DW]);
          chk("rdBusy_nobyp", x.id, i, DW'(ifN.RdBusy[i]),     DW'(x.bN[i]));
        end
        $display("txn %0d addr=%h byp=%h/%b nobyp=%h/%b", x.id, x.addr,
                 ifB.RdData, ifB.RdBusy, ifN.RdData, ifN.RdBusy);
      end
    end
  end

  initial begin
    for (int r = 0; r < 32; r++) begin
      modMem[r]  = '0;
      modPend[r] = 1'b0;
    end
    @(posedge clk);
    #1;
    // Reset state, including a write attempted while reset is held.
    step(rd3(5, 1, 31), 2'b01, wa2(5, 0), {32'h0, 32'h12345678}, 1'b1, 5'd5);
    step(rd3(5, 0, 31), 2'b00, '0, '0, 1'b0, 5'd0);
    rst_n = 1'b1;
    // Write x5, then assert reset mid-cycle: x5 must vanish immediately.
    step(rd3(5, 5, 0), 2'b01, wa2(5, 0), {32'h0, 32'hDEADBEEF}, 1'b0, 5'd0);
    step(rd3(5, 5, 5), 2'b00, '0, '0, 1'b0, 5'd0);
    rst_n = 1'b0;
    step(rd3(5, 5, 5), 2'b00, '0, '0, 1'b0, 5'd0);
    rst_n = 1'b1;
    step(rd3(5, 5, 5), 2'b00, '0, '0, 1'b0, 5'd0);
    // Same-address collision and x0 write.
    step(rd3(7, 0, 0), 2'b11, wa2(7, 7), {32'h22, 32'h11}, 1'b0, 5'd0);
    step(rd3(7, 7, 7), 2'b00, '0, '0, 1'b0, 5'd0);
    step(rd3(0, 0, 0), 2'b01, wa2(0, 0), {32'h0, 32'hFFFFFFFF}, 1'b0, 5'd0);
    step(rd3(0, 7, 0), 2'b00, '0, '0, 1'b0, 5'd0);
    // Bypass vs. stored read of x3.
    step(rd3(3, 0, 0), 2'b01, wa2(3, 0), {32'h0, 32'h0BAD0003}, 1'b0, 5'd0);
    step(rd3(3, 3, 0), 2'b01, wa2(3, 0), {32'h0, 32'hA5A5A5A5}, 1'b0, 5'd0);
    step(rd3(3, 3, 3), 2'b00, '0, '0, 1'b0, 5'd0);
    // Scoreboard on x9, write-back via port 1 three cycles after reserve.
    step(rd3(9, 0, 0), 2'b00, '0, '0, 1'b1, 5'd9);
    step(rd3(9, 9, 0), 2'b00, '0, '0, 1'b0, 5'd0);
    step(rd3(9, 0, 9), 2'b00, '0, '0, 1'b0, 5'd0);
    step(rd3(9, 9, 9), 2'b10, wa2(0, 9), {32'h1234, 32'h0}, 1'b0, 5'd0);
    step(rd3(9, 9, 9), 2'b00, '0, '0, 1'b0, 5'd0);
    // Reserve and write x4 together; reserve x0.
    step(rd3(4, 4, 0), 2'b01, wa2(4, 0), {32'h0, 32'h55}, 1'b1, 5'd4);
    step(rd3(4, 4, 4), 2'b00, '0, '0, 1'b1, 5'd0);
    step(rd3(0, 4, 0), 2'b00, '0, '0, 1'b0, 5'd0);
    // Random regression; small address window raises collision/bypass rates.
    for (int n = 0; n < NRAND; n++) begin
      logic [NRD*RA-1:0] r;
      logic [NWR*RA-1:0] a;
      logic [NWR*DW-1:0] d;
      bit narrow;
      narrow = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NRD; i++)
        r[i*RA +: RA] = narrow ? RA'($urandom_range(0, 7)) : RA'($urandom);
      for (int p = 0; p < NWR; p++) begin
        a[p*RA +: RA] = narrow ? RA'($urandom_range(0, 7)) : RA'($urandom);
        d[p*DW +: DW] = $urandom;
      end
      if ($urandom_range(0, 999) == 0) rst_n = 1'b0;
      else if (!rst_n && $urandom_range(0, 1) == 1) rst_n = 1'b1;
      step(r, NWR'($urandom), a, d, ($urandom_range(0, 2) == 0),
           narrow ? RA'($urandom_range(0, 7)) : RA'($urandom));
    end
    @(negedge clk);
    #1;
    checkCnt++;
    if (expQ.size() == 0) passCnt++;
    else $display("FAIL queue_drain got=%0d want=0", expQ.size());
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end
endmodule
